// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared constants for the integer pipeline register files.
//   XLEN_DEF   : default data width
//   NREGS_DEF  : default architectural register count
//   REG_ZERO   : index of the hardwired-zero register
//   addr_width : address bits needed to index n registers (at least 1)
package riscv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Per-register busy bits used by decode to detect RAW hazards against
// in-flight producers.
//   clk, rst  : clock, asynchronous active-high reset (clears all busy bits)
//   we        : per write port enable
//   rd_addr   : packed write addresses, port k at [k*AW +: AW]
//   rs_addr   : packed read addresses, port j at [j*AW +: AW]
//   iss_en    : an instruction writing iss_rd issues this cycle
//   iss_rd    : destination register of the issuing instruction
//   rs_busy   : busy flag of each read port's register
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] rd_addr,
  input  logic [NRD*AW-1:0] rs_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic [NRD-1:0]    rs_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Clears are applied first so that a same-cycle issue to the same
  // register overrides them: the newer producer is still outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (we[k]) begin
        busy_d[rd_addr[k*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rs_busy
    logic [AW-1:0] rs;
    logic          wr_hit;
    logic          iss_hit;

    assign rs      = rs_addr[j*AW +: AW];
    assign iss_hit = iss_en && (iss_rd == rs);

    always_comb begin
      wr_hit = 1'b0;
      for (int unsigned k = 0; k < NWR; k++) begin
        if (we[k] && (rd_addr[k*AW +: AW] == rs)) begin
          wr_hit = 1'b1;
        end
      end
    end

    // A write landing this cycle resolves the hazard for bypassed reads,
    // unless a new producer for the same register is issuing alongside.
    assign rs_busy[j] = busy_q[rs] & ~((BYPASS != 0) & wr_hit & ~iss_hit);
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port integer register file with optional write-to-read bypass and
// a busy scoreboard for RAW hazard detection.
//   clk, rst : clock, asynchronous active-high reset (all registers to 0)
//   we       : per write port enable
//   rd_addr  : packed write addresses, port k at [k*AW +: AW]
//   rd_data  : packed write data,      port k at [k*XLEN +: XLEN]
//   rs_addr  : packed read addresses,  port j at [j*AW +: AW]
//   rs_data  : packed combinational read data
//   rs_busy  : per read port, addressed register has a pending producer
//   iss_en   : issue of an instruction that writes iss_rd
//   iss_rd   : destination register of the issuing instruction
module regfile_mp
  import riscv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   rd_addr,
  input  logic [NWR*XLEN-1:0] rd_data,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Ports are scanned in ascending order so the highest-index port is the
  // last assignment and wins an address conflict.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (we[k] && (rd_addr[k*AW +: AW] != '0)) begin
        regs_d[rd_addr[k*AW +: AW]] = rd_data[k*XLEN +: XLEN];
      end
    end
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass is suppressed while reset is held so the read ports show the
  // cleared array rather than write data that will never be stored.
  logic byp_ok;
  assign byp_ok = (BYPASS != 0) && !rst;

  for (genvar j = 0; j < NRD; j++) begin : g_read
    logic [AW-1:0]   rs;
    logic [XLEN-1:0] rdata;

    assign rs = rs_addr[j*AW +: AW];

    always_comb begin
      rdata = regs_q[rs];
      if (byp_ok) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (we[k] && (rd_addr[k*AW +: AW] == rs)) begin
            rdata = rd_data[k*XLEN +: XLEN];
          end
        end
      end
      if (rs == '0) begin
        rdata = '0;
      end
    end

    assign rs_data[j*XLEN +: XLEN] = rdata;
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .rd_addr (rd_addr),
    .rs_addr (rs_addr),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .rs_busy (rs_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Drives a bypassing and a non-bypassing 32x32 instance with identical
// stimulus and checks both against a behavioural model every cycle; a third
// instance (16 regs, 4 read ports, 1 write port, 64-bit) is checked directly.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [9:0]  rs_addr;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic [63:0] rs_data_a, rs_data_b;
  logic [1:0]  rs_busy_a, rs_busy_b;

  logic         c_we;
  logic [3:0]   c_rd_addr;
  logic [63:0]  c_rd_data;
  logic [15:0]  c_rs_addr;
  logic [255:0] c_rs_data;
  logic [3:0]   c_rs_busy;
  logic         c_iss_en;
  logic [3:0]   c_iss_rd;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs_addr(rs_addr), .rs_data(rs_data_a), .rs_busy(rs_busy_a),
    .iss_en(iss_en), .iss_rd(iss_rd)
  );

  regfile_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
    .iss_en(iss_en), .iss_rd(iss_rd)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(1)) dut_c (
    .clk(clk), .rst(rst), .we(c_we), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .rs_addr(c_rs_addr), .rs_data(c_rs_data), .rs_busy(c_rs_busy),
    .iss_en(c_iss_en), .iss_rd(c_iss_rd)
  );

  // Behavioural model: architectural contents and pending-producer flags.
  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we[k] && rd_addr[k*5 +: 5] != 5'd0) m_mem[rd_addr[k*5 +: 5]] <= rd_data[k*32 +: 32];
        if (we[k]) m_busy[rd_addr[k*5 +: 5]] <= 1'b0;
      end
      if (iss_en && iss_rd != 5'd0) m_busy[iss_rd] <= 1'b1;
    end
  end

  function automatic logic write_hit(input logic [4:0] a);
    logic h = 1'b0;
    for (int k = 0; k < 2; k++) if (we[k] && rd_addr[k*5 +: 5] == a) h = 1'b1;
    return h;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    logic [31:0] r;
    if (a == 5'd0) return 32'h0;
    r = m_mem[a];
    if (byp) for (int k = 0; k < 2; k++) if (we[k] && rd_addr[k*5 +: 5] == a) r = rd_data[k*32 +: 32];
    return r;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && write_hit(a) && !(iss_en && iss_rd == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int j = 0; j < 2; j++) begin
        check($sformatf("p%0d_data_byp", j), {32'h0, rs_data_a[j*32 +: 32]}, {32'h0, exp_rd(rs_addr[j*5 +: 5], 1'b1)});
        check($sformatf("p%0d_data_nobyp", j), {32'h0, rs_data_b[j*32 +: 32]}, {32'h0, exp_rd(rs_addr[j*5 +: 5], 1'b0)});
        check($sformatf("p%0d_busy_byp", j), {63'h0, rs_busy_a[j]}, {63'h0, exp_busy(rs_addr[j*5 +: 5], 1'b1)});
        check($sformatf("p%0d_busy_nobyp", j), {63'h0, rs_busy_b[j]}, {63'h0, exp_busy(rs_addr[j*5 +: 5], 1'b0)});
      end
    end
  end

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    we = '0;
    iss_en = 1'b0;
    c_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    we = '0; rd_addr = '0; rd_data = '0; rs_addr = {5'd7, 5'd5};
    iss_en = 1'b0; iss_rd = '0;
    c_we = 1'b0; c_rd_addr = '0; c_rd_data = '0; c_rs_addr = '0;
    c_iss_en = 1'b0; c_iss_rd = '0;

    #7;
    check("reset_data", rs_data_a, 64'h0);
    check("reset_busy", {62'h0, rs_busy_a}, 64'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    chk_en = 1'b1;

    // Every register reads zero after reset.
    for (int r = 0; r < 32; r++) begin
      rs_addr = {5'(31 - r), 5'(r)};
      sample();
      check("reset_reg_p0", {32'h0, rs_data_a[31:0]}, 64'h0);
      check("reset_reg_p1", {32'h0, rs_data_b[63:32]}, 64'h0);
      adv();
    end

    // x0 ignores writes, including the bypass path.
    we = 2'b01; rd_addr = '0; rd_data = {32'h0, 32'hFFFF_FFFF}; rs_addr = '0;
    sample();
    check("x0_same_cycle", {32'h0, rs_data_a[31:0]}, 64'h0);
    adv();
    sample();
    check("x0_after", {32'h0, rs_data_a[31:0]}, 64'h0);

    // Basic writes on both ports.
    adv();
    we = 2'b11; rd_addr = {5'd7, 5'd5}; rd_data = {32'h1234_5678, 32'hDEAD_BEEF};
    adv();
    rs_addr = {5'd7, 5'd5};
    sample();
    check("x5_read", {32'h0, rs_data_b[31:0]}, 64'hDEAD_BEEF);
    check("x7_read", {32'h0, rs_data_b[63:32]}, 64'h1234_5678);
    check("model_x5", {32'h0, m_mem[5]}, 64'hDEAD_BEEF);

    // Conflict: port 1 wins.
    adv();
    we = 2'b11; rd_addr = {5'd9, 5'd9}; rd_data = {32'h2222, 32'h1111}; rs_addr = {5'd0, 5'd9};
    sample();
    check("conflict_byp", {32'h0, rs_data_a[31:0]}, 64'h2222);
    check("conflict_nobyp", {32'h0, rs_data_b[31:0]}, 64'h0);
    adv();
    sample();
    check("conflict_stored_a", {32'h0, rs_data_a[31:0]}, 64'h2222);
    check("conflict_stored_b", {32'h0, rs_data_b[31:0]}, 64'h2222);
    check("model_x9", {32'h0, m_mem[9]}, 64'h2222);

    // Scoreboard set, then clear by write.
    adv();
    iss_en = 1'b1; iss_rd = 5'd3; rs_addr = {5'd0, 5'd3};
    sample();
    check("busy_not_yet", {63'h0, rs_busy_a[0]}, 64'h0);
    adv();
    sample();
    check("busy_set_a", {63'h0, rs_busy_a[0]}, 64'h1);
    check("busy_set_b", {63'h0, rs_busy_b[0]}, 64'h1);
    adv();
    we = 2'b01; rd_addr = {5'd0, 5'd3}; rd_data = {32'h0, 32'h33};
    sample();
    check("busy_clear_byp", {63'h0, rs_busy_a[0]}, 64'h0);
    check("busy_clear_nobyp", {63'h0, rs_busy_b[0]}, 64'h1);
    adv();
    sample();
    check("busy_cleared", {62'h0, rs_busy_a[0], rs_busy_b[0]}, 64'h0);

    // Issue and write to the same register: issue wins.
    adv();
    iss_en = 1'b1; iss_rd = 5'd3; we = 2'b10; rd_addr = {5'd3, 5'd0}; rd_data = {32'h44, 32'h0};
    adv();
    sample();
    check("issue_wins", {62'h0, rs_busy_a[0], rs_busy_b[0]}, 64'h3);

    // Asynchronous reset between clock edges.
    adv();
    we = 2'b01; rd_addr = {5'd0, 5'd5}; rd_data = {32'h0, 32'hABCD}; iss_en = 1'b1; iss_rd = 5'd6;
    adv();
    rs_addr = {5'd6, 5'd5};
    sample();
    check("pre_rst_x5", {32'h0, rs_data_a[31:0]}, 64'hABCD);
    check("pre_rst_x6_busy", {63'h0, rs_busy_a[1]}, 64'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_x5", {32'h0, rs_data_a[31:0]}, 64'h0);
    check("async_rst_x6_busy", {62'h0, rs_busy_a[1], rs_busy_b[1]}, 64'h0);
    #1;
    rst = 1'b0;
    sample();
    check("post_rst_x5", {32'h0, rs_data_b[31:0]}, 64'h0);

    // Randomised traffic with a narrow address range to force conflicts.
    for (int n = 0; n < 500; n++) begin
      @(posedge clk);
      #1;
      we = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        rd_addr[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        rs_addr[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      end
      rd_data = {$urandom, $urandom};
      iss_en = ($urandom_range(0, 2) == 0);
      iss_rd = 5'($urandom_range(0, 7));
    end
    adv();

    // Wide, 4-read / 1-write configuration.
    c_we = 1'b1; c_rd_addr = 4'd15; c_rd_data = 64'h0123_4567_89AB_CDEF; c_rs_addr = {4{4'd15}};
    sample();
    check("sweep_bypass", c_rs_data[63:0], 64'h0123_4567_89AB_CDEF);
    adv();
    sample();
    for (int j = 0; j < 4; j++) begin
      check($sformatf("sweep_p%0d", j), c_rs_data[j*64 +: 64], 64'h0123_4567_89AB_CDEF);
    end
    check("sweep_busy", {60'h0, c_rs_busy}, 64'h0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V pipeline, successor to the single-write/dual-read `register_file`. It provides a configurable number of combinational read ports and clocked write ports, plus optional same-cycle write-to-read bypass. A per-register busy scoreboard lets decode detect RAW hazards against in-flight producers. It sits between decode (read, issue) and writeback (write, busy clear).

## Interface
Parameters:
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of architectural registers; power of two, ≥ 2.
- `NRD`, 2, number of read ports.
- `NWR`, 2, number of write ports.
- `BYPASS`, 1, 1 = a read of a register being written this cycle returns the write data; 0 = it returns the stored value.
- `AW`, $clog2(NREGS), derived address width; never overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `we`  in  NWR  write enable, one bit per write port.
- `rd_addr`  in  NWR*AW  write addresses; port k occupies bits [k*AW +: AW].
- `rd_data`  in  NWR*XLEN  write data, packed the same way.
- `rs_addr`  in  NRD*AW  read addresses, packed.
- `rs_data`  out  NRD*XLEN  read data, combinational.
- `rs_busy`  out  NRD  the addressed register has a pending producer.
- `iss_en`  in  1  issue of an instruction that writes `iss_rd`.
- `iss_rd`  in  AW  destination register of the issuing instruction.

## Operation
- Register 0 is hardwired: reads return 0, writes are ignored, and it is never busy. `iss_rd`=0 has no effect.
- **Write:** on a rising edge, every port k with `we[k]` and a non-zero address stores its data.
- **Write conflict:** if several write ports target the same address in one cycle, the highest-index port wins.
- **Read:** `rs_data[j]` is the stored value of `rs_addr[j]`.
  - If `BYPASS`=1 and some `we[k]` targets that address this cycle, `rs_data[j]` is the data of the highest-index such port.
  - For register 0, `rs_data[j]` is 0 regardless of writes.
- **Scoreboard:** one busy bit per register.
  - `iss_en` sets `busy[iss_rd]`.
  - Any valid write to address a clears `busy[a]`.
  - If a set and a clear hit the same register in the same cycle, the set wins and the bit stays busy (the newer producer is pending).
- **`rs_busy[j]`:** equals `busy[rs_addr[j]]`. With `BYPASS`=1, it is forced to 0 when a same-cycle write to that address is present and no same-cycle issue targets it.
- Writes to a non-busy register are legal: they update data and leave busy at 0.

## Timing
- Reset: all registers 0 and all busy bits 0, immediately on `rst` assertion regardless of `clk`. Consequently `rs_data` = 0 and `rs_busy` = 0 while `rst` is high.
- Write latency: data is visible to a non-bypassed read one cycle after the write edge; with `BYPASS`=1 it is visible in the same cycle.
- Issue latency: a busy bit set by `iss_en` is visible on `rs_busy` from the next cycle.
- A write or issue present on the same edge as `rst` deassertion is either fully applied or fully dropped; the bench does not depend on which.
- Read path is purely combinational; there is no read enable.

## Structure
- Shared package `riscv_pkg`: `XLEN_DEF`=32, `NREGS_DEF`=32, `REG_ZERO`=0, and the address-width function.
- Sub-module `regfile_scoreboard` holds the busy bits, set/clear priority, and `rs_busy` generation; parameters `NREGS`, `NRD`, `NWR`.
- Data array, write-port priority, and bypass muxes live in `regfile_mp`, with a generate loop per read port.

## Test plan
- Reset and x0: after `rst`, read x0..x31 → all 0x00000000. Write 0xFFFFFFFF to x0, then read x0 → 0x00000000.
- Basic write/read: port 0 writes x5=0xDEADBEEF; next cycle `rs_addr[0]`=5 → 0xDEADBEEF. Port 1 writes x7=0x12345678; `rs_addr[1]`=7 → 0x12345678.
- Conflict and bypass (`BYPASS`=1):
  - Both ports write x9 in one cycle, port 0 = 0x1111, port 1 = 0x2222; the same-cycle read of x9 → 0x2222 and the stored value → 0x2222.
  - Same stimulus with `BYPASS`=0: the same-cycle read returns the old value 0, and the next cycle returns 0x2222.
- Scoreboard:
  - `iss_en` with `iss_rd`=3 → `rs_busy` for x3 is 1 the next cycle.
  - A write to x3 clears it (0 in the same cycle with bypass, 0 afterwards).
  - Issue and write of x3 in the same cycle → x3 remains busy.
- Async reset mid-operation: after x5=0xABCD and x6 busy, pulse `rst` between clock edges → x5 reads 0 and x6 is not busy immediately, before the next edge.
- Parameter sweep: `NREGS`=16, `NRD`=4, `NWR`=1, `XLEN`=64. Write x15=0x0123456789ABCDEF, then all four read ports addressing x15 return that value.
